// File: rtl/serial_pkg.sv
// ============================================================================
// Module : serial_pkg
// Brief  : Shared FSM encodings and default framing parameters for serial RX/TX
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer for a single asynchronous input
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic AsyncIn,
  output logic SyncOut
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= AsyncIn;
      r_sync <= r_meta;
    end
  end

  assign SyncOut = r_sync;

endmodule

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ============================================================================
// Module : serial_frame_rx
// Brief  : Serial frame receiver with mid-bit sampling, even parity and stop check
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int PARITY_EN    = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 D,
  output logic [DATA_BITS-1:0] Data,
  output logic                 Valid,
  output logic                 ParErr,
  output logic                 FrameErr,
  output logic                 Busy
);

  localparam int c_tw = $clog2(CLKS_PER_BIT);
  localparam int c_bw = $clog2(DATA_BITS + 1);
  localparam logic [c_tw-1:0] c_half_m1  = c_tw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_tw-1:0] c_full_m1  = c_tw'(CLKS_PER_BIT - 1);
  localparam logic [c_bw-1:0] c_last_bit = c_bw'(DATA_BITS - 1);

  logic                 w_d_s;
  logic                 r_d_prev;
  state_e               r_state;
  state_e               w_state_next;
  logic [c_tw-1:0]      r_timer;
  logic [c_bw-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_par_err;
  logic                 w_fall;
  logic                 w_tick_half;
  logic                 w_tick_full;
  logic                 w_timer_clr;
  logic                 w_shift_en;
  logic                 w_par_en;
  logic                 w_stop_en;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_par_out;
  logic                 r_frame_out;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .Clk     (Clk),
    .Rst     (Rst),
    .AsyncIn (D),
    .SyncOut (w_d_s)
  );

  assign w_fall      = r_d_prev & ~w_d_s;
  assign w_tick_half = (r_timer == c_half_m1);
  assign w_tick_full = (r_timer == c_full_m1);

  // Payload arrives LSB first, so new bits enter at the MSB and shift down.
  generate
    if (DATA_BITS == 1) begin : g_shift_one
      assign w_shift_next = w_d_s;
    end else begin : g_shift_multi
      assign w_shift_next = {w_d_s, r_shift[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_clr  = 1'b0;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_stop_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_next = ST_START;
          w_timer_clr  = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick_half) begin
          w_timer_clr  = 1'b1;
          w_state_next = w_d_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick_full) begin
          w_timer_clr = 1'b1;
          w_shift_en  = 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick_full) begin
          w_timer_clr  = 1'b1;
          w_par_en     = 1'b1;
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick_full) begin
          w_timer_clr  = 1'b1;
          w_stop_en    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_d_prev    <= 1'b1;
      r_timer     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_par_out   <= 1'b0;
      r_frame_out <= 1'b0;
    end else begin
      r_d_prev <= w_d_s;
      r_valid  <= 1'b0;

      if (w_timer_clr || (r_state == ST_IDLE)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (r_state == ST_START) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_shift_en) begin
        r_shift <= w_shift_next;
      end

      if (r_state == ST_START) begin
        r_par_err <= 1'b0;
      end else if (w_par_en) begin
        r_par_err <= (^r_shift) ^ w_d_s;
      end

      // Results are published together with Valid and held until the next frame.
      if (w_stop_en) begin
        r_valid     <= 1'b1;
        r_data      <= r_shift;
        r_par_out   <= (PARITY_EN != 0) ? r_par_err : 1'b0;
        r_frame_out <= ~w_d_s;
      end
    end
  end

  assign Data     = r_data;
  assign Valid    = r_valid;
  assign ParErr   = r_par_out;
  assign FrameErr = r_frame_out;
  assign Busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire
